// File: rtl/spsram_rr_arbiter_if.sv
// Bus bundle between two requesters, the round-robin arbiter and one
// registered-read single-port SRAM macro.
interface spsram_rr_arbiter_if #(
  parameter int BW_DATA = 32,
  parameter int BW_ADDR = 4
);
  // requester port 0
  logic               i_req0;
  logic               i_wen0;
  logic [BW_ADDR-1:0] i_addr0;
  logic [BW_DATA-1:0] i_data0;
  logic               o_gnt0;
  logic               o_rvalid0;
  // requester port 1
  logic               i_req1;
  logic               i_wen1;
  logic [BW_ADDR-1:0] i_addr1;
  logic [BW_DATA-1:0] i_data1;
  logic               o_gnt1;
  logic               o_rvalid1;
  // shared read return
  logic [BW_DATA-1:0] o_rdata;
  // SRAM pins
  logic               o_mem_cen;
  logic               o_mem_wen;
  logic               o_mem_oen;
  logic [BW_ADDR-1:0] o_mem_addr;
  logic [BW_DATA-1:0] o_mem_data;
  logic [BW_DATA-1:0] i_mem_data;

  // arbiter side
  modport slave (
    input  i_req0, i_wen0, i_addr0, i_data0,
    input  i_req1, i_wen1, i_addr1, i_data1,
    input  i_mem_data,
    output o_gnt0, o_rvalid0, o_gnt1, o_rvalid1, o_rdata,
    output o_mem_cen, o_mem_wen, o_mem_oen, o_mem_addr, o_mem_data
  );

  // requester / SRAM side
  modport master (
    output i_req0, i_wen0, i_addr0, i_data0,
    output i_req1, i_wen1, i_addr1, i_data1,
    output i_mem_data,
    input  o_gnt0, o_rvalid0, o_gnt1, o_rvalid1, o_rdata,
    input  o_mem_cen, o_mem_wen, o_mem_oen, o_mem_addr, o_mem_data
  );
endinterface

// File: rtl/spsram_rr_arbiter.sv
// Two-port round-robin arbiter in front of a registered-read single-port
// SRAM. One access per cycle; a streaming owner may keep the SRAM for up to
// MAX_HOLD consecutive grants while the other port waits. Read data comes
// back one cycle after the grant with a per-port valid strobe.
module spsram_rr_arbiter #(
  parameter int BW_DATA  = 32,
  parameter int BW_ADDR  = 4,
  parameter int MAX_HOLD = 4
) (
  input logic                i_clk,
  input logic                i_rst,
  spsram_rr_arbiter_if.slave bus
);

  localparam int CNT_W = $clog2(MAX_HOLD + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_HOLD);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic               last;      // last granted port
  logic [CNT_W-1:0]   cnt;       // consecutive grants to last, saturates
  logic               rd_pend0;
  logic               rd_pend1;
  logic               gnt0;
  logic               gnt1;
  logic               mem_cen;
  logic               mem_wen;
  logic               mem_oen;
  logic [BW_ADDR-1:0] mem_addr;
  logic [BW_DATA-1:0] mem_data;

  // Grant decision: lone requester wins; under contention the owner keeps
  // the SRAM until its hold budget is spent, then it passes to the other.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (!i_rst) begin
      if (bus.i_req0 && bus.i_req1) begin
        if (cnt < CNT_MAX) begin
          gnt0 = ~last;
          gnt1 = last;
        end else begin
          gnt0 = last;
          gnt1 = ~last;
        end
      end else begin
        gnt0 = bus.i_req0;
        gnt1 = bus.i_req1;
      end
    end
  end

  // Ownership tracking; an idle cycle saturates cnt so the lock is released.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      last <= 1'b1;
      cnt  <= CNT_MAX;
    end else if (gnt0 || gnt1) begin
      if (gnt1 == last) begin
        cnt <= (cnt == CNT_MAX) ? CNT_MAX : cnt + CNT_ONE;
      end else begin
        last <= gnt1;
        cnt  <= CNT_ONE;
      end
    end else begin
      cnt <= CNT_MAX;
    end
  end

  // SRAM pin mux: granted port drives the macro, all pins low otherwise.
  always_comb begin
    mem_cen  = 1'b0;
    mem_wen  = 1'b0;
    mem_oen  = 1'b0;
    mem_addr = '0;
    mem_data = '0;
    if (gnt0) begin
      mem_cen  = 1'b1;
      mem_wen  = bus.i_wen0;
      mem_oen  = 1'b1;
      mem_addr = bus.i_addr0;
      mem_data = bus.i_data0;
    end else if (gnt1) begin
      mem_cen  = 1'b1;
      mem_wen  = bus.i_wen1;
      mem_oen  = 1'b1;
      mem_addr = bus.i_addr1;
      mem_data = bus.i_data1;
    end
  end

  // Read-pending flags line up with the SRAM's one-cycle registered read.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      rd_pend0 <= 1'b0;
      rd_pend1 <= 1'b0;
    end else begin
      rd_pend0 <= gnt0 & ~bus.i_wen0;
      rd_pend1 <= gnt1 & ~bus.i_wen1;
    end
  end

  assign bus.o_gnt0     = gnt0;
  assign bus.o_gnt1     = gnt1;
  // A read granted just before reset must not surface during the reset cycle.
  assign bus.o_rvalid0  = rd_pend0 & ~i_rst;
  assign bus.o_rvalid1  = rd_pend1 & ~i_rst;
  assign bus.o_rdata    = bus.i_mem_data;
  assign bus.o_mem_cen  = mem_cen;
  assign bus.o_mem_wen  = mem_wen;
  assign bus.o_mem_oen  = mem_oen;
  assign bus.o_mem_addr = mem_addr;
  assign bus.o_mem_data = mem_data;

endmodule

// File: tb/tb_spsram_rr_arbiter.sv
// Scoreboard bench for spsram_rr_arbiter: dut 0 built with MAX_HOLD=4,
// dut 1 with MAX_HOLD=1, each attached to a small registered-read SRAM model.
module tb_spsram_rr_arbiter;

  typedef struct {
    int          cyc;
    int          port;
    logic        wen;
    logic [3:0]  addr;
    logic [31:0] data;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_err = 0;

  // stimulus side, index = dut
  logic [1:0]  rst  = 2'b11;
  logic [1:0]  req0 = 2'b00;
  logic [1:0]  wen0 = 2'b00;
  logic [1:0]  req1 = 2'b00;
  logic [1:0]  wen1 = 2'b00;
  logic [3:0]  addr0 [2];
  logic [3:0]  addr1 [2];
  logic [31:0] data0 [2];
  logic [31:0] data1 [2];

  // observed side
  logic [1:0]  g0, g1, rv0, rv1, cen, wen_o, oen;
  logic [3:0]  maddr [2];
  logic [31:0] mdata [2];
  logic [31:0] rdata [2];

  // SRAM models and shadow of expected contents
  logic [31:0] mem [2][16];
  logic [31:0] q   [2];
  logic [31:0] sh  [2][16];

  exp_t gq0[$], gq1[$], rq0[$], rq1[$];

  spsram_rr_arbiter_if #(.BW_DATA(32), .BW_ADDR(4)) ifa ();
  spsram_rr_arbiter_if #(.BW_DATA(32), .BW_ADDR(4)) ifb ();

  spsram_rr_arbiter #(.BW_DATA(32), .BW_ADDR(4), .MAX_HOLD(4)) dut_a (
    .i_clk(clk), .i_rst(rst[0]), .bus(ifa.slave));
  spsram_rr_arbiter #(.BW_DATA(32), .BW_ADDR(4), .MAX_HOLD(1)) dut_b (
    .i_clk(clk), .i_rst(rst[1]), .bus(ifb.slave));

  assign ifa.i_req0 = req0[0];  assign ifa.i_wen0 = wen0[0];
  assign ifa.i_addr0 = addr0[0]; assign ifa.i_data0 = data0[0];
  assign ifa.i_req1 = req1[0];  assign ifa.i_wen1 = wen1[0];
  assign ifa.i_addr1 = addr1[0]; assign ifa.i_data1 = data1[0];
  assign ifa.i_mem_data = q[0];
  assign ifb.i_req0 = req0[1];  assign ifb.i_wen0 = wen0[1];
  assign ifb.i_addr0 = addr0[1]; assign ifb.i_data0 = data0[1];
  assign ifb.i_req1 = req1[1];  assign ifb.i_wen1 = wen1[1];
  assign ifb.i_addr1 = addr1[1]; assign ifb.i_data1 = data1[1];
  assign ifb.i_mem_data = q[1];

  assign g0[0] = ifa.o_gnt0;  assign g1[0] = ifa.o_gnt1;
  assign rv0[0] = ifa.o_rvalid0; assign rv1[0] = ifa.o_rvalid1;
  assign cen[0] = ifa.o_mem_cen; assign wen_o[0] = ifa.o_mem_wen; assign oen[0] = ifa.o_mem_oen;
  assign maddr[0] = ifa.o_mem_addr; assign mdata[0] = ifa.o_mem_data; assign rdata[0] = ifa.o_rdata;
  assign g0[1] = ifb.o_gnt0;  assign g1[1] = ifb.o_gnt1;
  assign rv0[1] = ifb.o_rvalid0; assign rv1[1] = ifb.o_rvalid1;
  assign cen[1] = ifb.o_mem_cen; assign wen_o[1] = ifb.o_mem_wen; assign oen[1] = ifb.o_mem_oen;
  assign maddr[1] = ifb.o_mem_addr; assign mdata[1] = ifb.o_mem_data; assign rdata[1] = ifb.o_rdata;

  // registered-read single-port SRAM
  always @(posedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (cen[d]) begin
        if (wen_o[d]) mem[d][maddr[d]] <= mdata[d];
        else          q[d] <= mem[d][maddr[d]];
      end
    end
  end

  task automatic chk(input string nm, input int d, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s dut%0d cyc %0d: got %0h, expected %0h", nm, d, cyc, act, req);
    end
  endtask

  task automatic push_g(input int d, input exp_t e);
    if (d == 0) gq0.push_back(e); else gq1.push_back(e);
  endtask

  task automatic push_r(input int d, input exp_t e);
    if (d == 0) rq0.push_back(e); else rq1.push_back(e);
  endtask

  // monitor: pops an expectation whenever the DUT shows a grant or rvalid
  task automatic mon(input int d);
    exp_t e;
    int   gsz, rsz;
    gsz = (d == 0) ? gq0.size() : gq1.size();
    rsz = (d == 0) ? rq0.size() : rq1.size();
    if (g0[d] && g1[d]) chk("both_gnt", d, 64'(2'b11), 64'(2'b01));
    if (g0[d] || g1[d]) begin
      if (gsz == 0) begin
        chk("spurious_gnt", d, 64'({g1[d], g0[d]}), 64'd0);
      end else begin
        if (d == 0) e = gq0.pop_front(); else e = gq1.pop_front();
        chk("gnt_port", d, 64'(g1[d]), 64'(e.port));
        chk("gnt_cycle", d, 64'(cyc), 64'(e.cyc));
        chk("mem_ctrl", d, 64'({cen[d], oen[d], wen_o[d]}), 64'({2'b11, e.wen}));
        chk("mem_addr", d, 64'(maddr[d]), 64'(e.addr));
        chk("mem_data", d, 64'(mdata[d]), 64'(e.data));
      end
    end else begin
      chk("idle_pins", d, {27'd0, cen[d], wen_o[d], oen[d], maddr[d], mdata[d]}, 64'd0);
    end
    if (rv0[d] || rv1[d]) begin
      if (rv0[d] && rv1[d]) chk("both_rvalid", d, 64'(2'b11), 64'(2'b01));
      if (rsz == 0) begin
        chk("spurious_rvalid", d, 64'({rv1[d], rv0[d]}), 64'd0);
      end else begin
        if (d == 0) e = rq0.pop_front(); else e = rq1.pop_front();
        chk("rv_port", d, 64'(rv1[d]), 64'(e.port));
        chk("rv_cycle", d, 64'(cyc), 64'(e.cyc));
        chk("rdata", d, 64'(rdata[d]), 64'(e.data));
      end
    end
  endtask

  always @(negedge clk) begin
    mon(0);
    mon(1);
  end

  // one cycle of stimulus; ep = expected granted port (-1 none)
  task automatic step(input int d, input bit rs,
                      input bit r0, input bit w0, input int a0, input logic [31:0] d0,
                      input bit r1, input bit w1, input int a1, input logic [31:0] d1,
                      input int ep, input bit keep_rd = 1'b1);
    exp_t e;
    rst[d] = rs;
    req0[d] = r0; wen0[d] = w0; addr0[d] = 4'(a0); data0[d] = d0;
    req1[d] = r1; wen1[d] = w1; addr1[d] = 4'(a1); data1[d] = d1;
    if (ep >= 0) begin
      e.cyc  = cyc;
      e.port = ep;
      e.wen  = (ep == 1) ? w1 : w0;
      e.addr = (ep == 1) ? 4'(a1) : 4'(a0);
      e.data = (ep == 1) ? d1 : d0;
      push_g(d, e);
      if (e.wen) begin
        sh[d][e.addr] = e.data;
      end else if (keep_rd) begin
        e.cyc  = cyc + 1;
        e.data = sh[d][e.addr];
        push_r(d, e);
      end
    end
    @(negedge clk);
    if (rs) begin
      chk("rst_ctrl", d, 64'({g0[d], g1[d], cen[d], wen_o[d], oen[d], rv0[d], rv1[d]}), 64'd0);
      chk("rst_bus", d, {28'd0, maddr[d], mdata[d]}, 64'd0);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int d);
    step(d, 1'b0, 1'b0, 1'b0, 0, 32'h0, 1'b0, 1'b0, 0, 32'h0, -1);
  endtask

  int pat_a [12] = '{0, 0, 0, 0, 1, 1, 1, 1, 0, 0, 0, 0};

  initial begin
    int p0, p1;
    for (int d = 0; d < 2; d++) begin
      q[d] = 32'h0;
      addr0[d] = 4'h0; addr1[d] = 4'h0; data0[d] = 32'h0; data1[d] = 32'h0;
      for (int a = 0; a < 16; a++) begin
        mem[d][a] = 32'h0;
        sh[d][a]  = 32'h0;
      end
    end
    @(posedge clk);
    #1;

    // ---- dut 0, MAX_HOLD=4 ----
    // reset with both requesting: nothing granted, SRAM untouched
    step(0, 1'b1, 1'b1, 1'b1, 0, 32'hDEAD_0000, 1'b1, 1'b1, 1, 32'hDEAD_0001, -1);
    step(0, 1'b1, 1'b1, 1'b1, 0, 32'hDEAD_0000, 1'b1, 1'b1, 1, 32'hDEAD_0001, -1);
    // first contested grant after reset goes to port 0
    step(0, 1'b0, 1'b1, 1'b1, 0, 32'h0000_0011, 1'b1, 1'b1, 1, 32'h0000_0022, 0);
    step(0, 1'b0, 1'b0, 1'b0, 0, 32'h0,         1'b1, 1'b1, 1, 32'h0000_0022, 1);
    idle(0);
    // single port write then read back
    step(0, 1'b0, 1'b1, 1'b1, 3, 32'hA5A5_A5A5, 1'b0, 1'b0, 0, 32'h0, 0);
    step(0, 1'b0, 1'b1, 1'b0, 3, 32'h0,         1'b0, 1'b0, 0, 32'h0, 0);
    idle(0);
    // set ownership to port 1, then release it with an idle cycle
    step(0, 1'b0, 1'b0, 1'b0, 0, 32'h0, 1'b1, 1'b0, 1, 32'h0, 1);
    idle(0);
    // contention: 4 grants each in turn
    for (int i = 0; i < 12; i++)
      step(0, 1'b0, 1'b1, 1'b0, 3, 32'h0000_1234, 1'b1, 1'b0, 1, 32'h0000_5678, pat_a[i]);
    // port 1 twice (write then read-after-write), idle, then both -> port 0
    step(0, 1'b0, 1'b0, 1'b0, 0, 32'h0, 1'b1, 1'b1, 5, 32'h0000_0055, 1);
    step(0, 1'b0, 1'b0, 1'b0, 0, 32'h0, 1'b1, 1'b0, 5, 32'h0,         1);
    idle(0);
    step(0, 1'b0, 1'b1, 1'b0, 0, 32'h0, 1'b1, 1'b0, 5, 32'h0, 0);
    step(0, 1'b0, 1'b0, 1'b0, 0, 32'h0, 1'b1, 1'b0, 5, 32'h0, 1);
    idle(0);
    // reset right after a port 1 read grant: the read never returns
    step(0, 1'b0, 1'b0, 1'b0, 0, 32'h0, 1'b1, 1'b0, 1, 32'h0, 1, 1'b0);
    step(0, 1'b1, 1'b0, 1'b0, 0, 32'h0, 1'b0, 1'b0, 0, 32'h0, -1);
    idle(0);
    idle(0);
    // memory survives reset
    step(0, 1'b0, 1'b1, 1'b0, 0, 32'h0, 1'b0, 1'b0, 0, 32'h0, 0);
    idle(0);
    idle(0);

    // ---- dut 1, MAX_HOLD=1 ----
    step(1, 1'b1, 1'b0, 1'b0, 0, 32'h0, 1'b0, 1'b0, 0, 32'h0, -1);
    // both write continuously: port 0 ascends 0..7, port 1 descends 7..0
    p0 = 0;
    p1 = 0;
    for (int i = 0; i < 16; i++) begin
      step(1, 1'b0, 1'b1, 1'b1, p0, 32'hB000_0000 | 32'(p0),
                    1'b1, 1'b1, 7 - p1, 32'hC000_0000 | 32'(7 - p1), i % 2);
      if (i % 2 == 0) p0++; else p1++;
    end
    // alternating readback: addrs 0..3 last written by port 1, 4..7 by port 0
    p0 = 0;
    p1 = 0;
    for (int i = 0; i < 8; i++) begin
      step(1, 1'b0, 1'b1, 1'b0, p0, 32'h0, 1'b1, 1'b0, 4 + p1, 32'h0, i % 2);
      if (i % 2 == 0) p0++; else p1++;
    end
    idle(1);
    idle(1);
    chk("readback_addr0", 1, 64'(sh[1][0]), 64'h0000_0000_C000_0000);
    chk("readback_addr7", 1, 64'(sh[1][7]), 64'h0000_0000_B000_0007);

    // every expectation consumed
    chk("gq0_left", 0, 64'(gq0.size()), 64'd0);
    chk("rq0_left", 0, 64'(rq0.size()), 64'd0);
    chk("gq1_left", 1, 64'(gq1.size()), 64'd0);
    chk("rq1_left", 1, 64'(rq1.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/spsram_rr_arbiter.md
Name: spsram_rr_arbiter

Overview:
Two-requester round-robin arbiter sharing one single-port SRAM macro, the registered-read spsram type with wen/cen/oen controls and a 1-cycle read latency.
- Grants one access per cycle.
- Drives the SRAM pins from the granted requester.
- Returns read data with a per-port valid strobe one cycle after grant.
- A bounded hold counter lets a streaming requester keep ownership for up to MAX_HOLD consecutive cycles before it must yield to a waiting requester.

Parameters:
BW_DATA, 32, data width of SRAM and requester buses
BW_ADDR, 4, SRAM address width
MAX_HOLD, 4, max consecutive grants to one port while the other is requesting (legal range >= 1)

Ports:
i_clk  input  1  clock; all state updates on its rising edge
i_rst  input  1  reset; one clock; reset is synchronous and active-high
i_req0  input  1  port 0 access request
i_wen0  input  1  port 0 write enable (1=write, 0=read)
i_addr0  input  BW_ADDR  port 0 address
i_data0  input  BW_DATA  port 0 write data
o_gnt0  output  1  port 0 grant; the access is performed this cycle
o_rvalid0  output  1  port 0 read data valid on o_rdata
i_req1, i_wen1, i_addr1, i_data1, o_gnt1, o_rvalid1  same widths and meaning as port 0, for port 1
o_rdata  output  BW_DATA  shared read return data
o_mem_cen  output  1  SRAM chip enable
o_mem_wen  output  1  SRAM write enable
o_mem_oen  output  1  SRAM output enable
o_mem_addr  output  BW_ADDR  SRAM address
o_mem_data  output  BW_DATA  SRAM write data
i_mem_data  input  BW_DATA  SRAM registered read data

Behaviour:
- State: last (1 bit, last granted port), cnt (0..MAX_HOLD, consecutive grants to last), rd_pend0/rd_pend1 (registered).
- Reset values: last=1, cnt=MAX_HOLD, rd_pend=0. Hence o_rvalid0=o_rvalid1=0 and the first contested cycle after reset grants port 0.
- While i_rst=1: o_gnt0=o_gnt1=0 and all o_mem_* = 0. Requests are ignored and no SRAM access occurs.
- Grant decision (combinational, same cycle as request):
  - Only one port requesting: grant it.
  - Both requesting and cnt < MAX_HOLD: grant last.
  - Both requesting and cnt == MAX_HOLD: grant the other port.
  - No request: no grant.
- o_gnt0 and o_gnt1 are never both 1.
- Counter update at clock edge:
  - Granted port == last: cnt = min(cnt+1, MAX_HOLD).
  - Granted port != last: last = granted port, cnt = 1.
  - No grant: last unchanged, cnt = MAX_HOLD (idle releases the lock, so the next contested grant goes to the other port).
- SRAM drive:
  - On a grant: o_mem_cen=1, o_mem_wen=granted i_wenN, o_mem_oen=1, and o_mem_addr/o_mem_data = granted port's address/data.
  - No grant: cen=0, wen=0, oen=0, addr=0, data=0.
- Read return:
  - rd_pendN <= o_gntN & ~i_wenN.
  - o_rvalidN = rd_pendN.
  - o_rdata = i_mem_data (pass-through; meaningful only while an rvalid is 1).
  - Fixed latency: data is valid exactly 1 cycle after grant.
  - Back-to-back reads from alternating ports each produce one rvalid, in grant order.
- Writes: grant is the completion; there is no response strobe. A read granted the cycle after a write to the same address returns the new data.
- Requester contract: hold i_reqN and its address/data/wen stable until o_gntN=1. A request may be dropped without a grant; the arbiter keeps no memory of it.
- Reset mid-operation: a read granted in the cycle before reset asserts yields no rvalid. rd_pend clears at the reset edge and the in-flight data is discarded.
- MAX_HOLD=1 under continuous contention: strict alternation 0,1,0,1,...

Test Plan:
- Reset then idle: i_rst=1 for 2 cycles with both req=1 -> no gnt, o_mem_cen=0, rvalid=0. After release, first grant = port 0.
- Single port: port0 writes 0xA5A5A5A5 @ addr 3 (gnt0 same cycle), then reads addr 3 -> o_rvalid0=1 the next cycle with o_rdata=0xA5A5A5A5, rvalid1 stays 0.
- Contention, MAX_HOLD=4: both req reads held high for 12 cycles -> gnt pattern 0,0,0,0,1,1,1,1,0,0,0,0. Each rvalid follows its gnt by 1 cycle.
- Idle release: port1 granted 2 cycles, 1 idle cycle, then both req -> port0 granted (cnt reset to MAX_HOLD by idle).
- Reset mid-read: port1 read granted at cycle N, i_rst=1 at cycle N+1 -> o_rvalid1=0 at N+1, no later rvalid.
- MAX_HOLD=1 build: both ports write addrs 0..7 continuously -> strict 0,1,0,1 alternation. Readback of all 8 addresses returns the last written values.
